div_iterative: RTL and testbench
================================

// Module: div_iterative
// PURPOSE
//   Multi-cycle radix-2 restoring divider, signed or unsigned.
//   It is the arithmetic core below the divide controller (divider_primary).
//   That controller drives start_i, signed_div_i and the operands, and stalls the pipeline until ready_o.
//   Result is packed for the HI/LO write: {remainder, quotient}.
// PARAMETERS
//   WIDTH  32  operand width; quotient and remainder are WIDTH bits each
// PORTS
//   clk           in   1        clock, all state on rising edge
//   rst           in   1        reset, asynchronous, active-low (0 = reset)
//   signed_div_i  in   1        1 = two's-complement divide, 0 = unsigned
//   opdata1_i     in   WIDTH    dividend
//   opdata2_i     in   WIDTH    divisor
//   start_i       in   1        request; held high by controller until ready_o
//   annul_i       in   1        abort in-flight divide (flush/exception)
//   result_o      out  2*WIDTH  [2W-1:W] remainder, [W-1:0] quotient
//   ready_o       out  1        result_o valid
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE, cnt=0, result_o=0, ready_o=0, operand regs=0.
//   States: IDLE, DZERO, BUSY, DONE. Outputs are registered.
//   IDLE
//     - start_i=1 and annul_i=0 and opdata2_i=0 -> DZERO.
//     - start_i=1 and annul_i=0 and opdata2_i!=0 -> BUSY, cnt=0.
//       Latch |opdata1_i| and |opdata2_i| (abs only if signed_div_i=1).
//       Latch both sign bits and signed_div_i.
//     - otherwise stay in IDLE; result_o=0, ready_o=0.
//   DZERO
//     - annul_i=1 -> IDLE.
//     - else -> DONE, result_o=0, ready_o=1.
//   BUSY
//     - One quotient bit per edge. Working register is 2W+1 bits.
//       diff = upper W+1 bits - {0,divisor}.
//       If diff >= 0: shift in 1 and keep diff; else shift in 0 and restore.
//       cnt increments each edge.
//     - annul_i=1 (any cycle) -> IDLE. No result; ready_o stays 0.
//     - On the edge with cnt=WIDTH -> DONE. This edge applies the sign fix and loads result_o; ready_o=1.
//   DONE
//     - result_o and ready_o held while start_i=1.
//     - start_i=0 -> IDLE; result_o<=0, ready_o<=0.
//     - annul_i is ignored in DONE.
//   Sign rules
//     - quotient is negated iff signed and the operand signs differ.
//     - remainder takes the dividend's sign.
//     - -2^(W-1) / -1 yields quotient 0x8000_0000, remainder 0 (wraps, no trap).
//   Latency (start sampled on edge 0)
//     - normal divide: ready_o high after edge WIDTH+1 (33 for W=32).
//     - divide-by-zero: ready_o high after edge 1.
//   Operand inputs are don't-care after the start edge; later changes must not affect the result.
//   start_i falling mid-BUSY without annul_i does not abort; the divide completes.
//   ready_o is never high for two divides without an intervening IDLE cycle.
// STRUCTURE
//   Shared header (with aludefines.vh):
//     - state encodings DIV_IDLE/DIV_DZERO/DIV_BUSY/DIV_DONE (2-bit)
//     - DIV_WIDTH
//   Sub-module div_step: combinational single-iteration subtract/compare/shift, W+1-bit.
//   Top holds the FSM, counter, operand regs, sign fix.
// TESTING
//   1. Unsigned 100/7 -> after 33 edges ready_o=1, result_o=64'h00000002_0000000E.
//   2. Signed -7/2 -> result_o=64'hFFFFFFFF_FFFFFFFD.
//      Signed 7/-2 -> result_o=64'h00000001_FFFFFFFD.
//   3. Signed 0x80000000/0xFFFFFFFF -> result_o=64'h00000000_80000000.
//      Unsigned 0xFFFFFFFF/1 -> result_o=64'h00000000_FFFFFFFF.
//   4. Divide by zero (any sign) -> ready_o=1 after edge 1, result_o=0.
//      Drop start_i -> IDLE next edge.
//   5. Annul: annul_i=1 on BUSY edge 10 -> IDLE, ready_o never rises.
//      Immediate new start 9/3 -> result_o=64'h0_00000003 after 33 edges.
//   6. rst=0 mid-BUSY (async, between edges) -> outputs 0 at once.
//      After release, a fresh start divides correctly.
//      Also: opdata toggled during BUSY does not change the result.

Source files
------------

// File: rtl/div_iterative_pkg.sv
// -----------------------------------------------------------------------------
// div_iterative_pkg
// Purpose : Shared definitions for the iterative divider slice: the default
//           operand width and the 2-bit FSM state encoding used by the top.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package div_iterative_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'b00,
    DIV_DZERO = 2'b01,
    DIV_BUSY  = 2'b10,
    DIV_DONE  = 2'b11
  } divState_t;

endpackage

// File: rtl/div_iterative_if.sv
// -----------------------------------------------------------------------------
// div_iterative_if
// Purpose : Request/response bundle between the divide controller (master)
//           and the iterative divider core (slave).
// Signals : signed_div_i  1 = two's-complement divide, 0 = unsigned
//           opdata1_i     dividend
//           opdata2_i     divisor
//           start_i       request, held high until ready_o
//           annul_i       abort an in-flight divide
//           result_o      {remainder, quotient}
//           ready_o       result_o valid
// -----------------------------------------------------------------------------
interface div_iterative_if
  import div_iterative_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  // The controller side drives the request and consumes the result
  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  // The divider core consumes the request and drives the result
  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );

endinterface

// File: rtl/div_iterative_step.sv
// -----------------------------------------------------------------------------
// div_iterative_step
// Purpose : One combinational restoring-division iteration. The working
//           register holds {partial remainder (W+1 bits), dividend/quotient
//           bits (W bits)}. It is shifted left once, then the divisor is
//           trial-subtracted from the upper W+1 bits.
// Ports   : i_work     working register before the iteration (2W+1 bits)
//           i_divisor  magnitude of the divisor (W bits)
//           o_work     working register after the iteration (2W+1 bits)
// -----------------------------------------------------------------------------
module div_iterative_step
  import div_iterative_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] i_work,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [2*WIDTH:0] o_work
);

  logic [2*WIDTH:0] w_shifted;
  logic [WIDTH+1:0] w_diff;
  logic             w_unusedMsb;

  // The partial remainder is always below the divisor, so the top bit of the
  // working register is zero on entry and is dropped by the shift.
  assign w_unusedMsb = i_work[2*WIDTH];
  assign w_shifted   = {i_work[2*WIDTH-1:0], 1'b0};

  // One extra bit on the subtraction gives the sign of the trial difference
  assign w_diff = {1'b0, w_shifted[2*WIDTH:WIDTH]} - {2'b00, i_divisor};

  // A non-negative difference becomes the new remainder and shifts in a 1;
  // otherwise the shifted value (already carrying a 0) is kept as the restore.
  assign o_work = w_diff[WIDTH+1] ? w_shifted
                                  : {w_diff[WIDTH:0], w_shifted[WIDTH-1:1], 1'b1};

endmodule

// File: rtl/div_iterative.sv
// -----------------------------------------------------------------------------
// div_iterative
// Purpose : Multi-cycle radix-2 restoring divider, signed or unsigned, sitting
//           under the divide controller. Produces {remainder, quotient}.
// Ports   : clk  clock, all state on the rising edge
//           rst  asynchronous reset, active-low
//           bus  div_iterative_if.slave (operands, start/annul, result/ready)
// -----------------------------------------------------------------------------
module div_iterative
  import div_iterative_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  div_iterative_if.slave   bus
);

  localparam int                   CNT_WIDTH = $clog2(WIDTH + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT  = CNT_WIDTH'(WIDTH);

  divState_t          r_state;
  divState_t          w_nextState;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2*WIDTH:0]   r_work;
  logic [2*WIDTH:0]   w_stepWork;
  logic [WIDTH-1:0]   r_divisor;
  logic               r_dividendNeg;
  logic               r_divisorNeg;
  logic               r_signedDiv;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;

  logic               w_accept;
  logic               w_divisorZero;
  logic [WIDTH-1:0]   w_absDividend;
  logic [WIDTH-1:0]   w_absDivisor;
  logic [WIDTH-1:0]   w_quotient;
  logic [WIDTH-1:0]   w_remainder;

  logic               w_loadOperands;
  logic               w_doStep;
  logic               w_loadResult;
  logic               w_setZeroResult;
  logic               w_clearOutputs;

  assign w_accept      = bus.start_i && !bus.annul_i;
  assign w_divisorZero = (bus.opdata2_i == '0);

  // Operands are divided as magnitudes; the most negative value negates to
  // itself, which is the correct unsigned magnitude 2^(W-1).
  assign w_absDividend = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i
                                                                      : bus.opdata1_i;
  assign w_absDivisor  = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i
                                                                      : bus.opdata2_i;

  // Sign fix: quotient negative when signs differ, remainder follows dividend
  assign w_quotient  = (r_signedDiv && (r_dividendNeg ^ r_divisorNeg)) ? -r_work[WIDTH-1:0]
                                                                       : r_work[WIDTH-1:0];
  assign w_remainder = (r_signedDiv && r_dividendNeg) ? -r_work[2*WIDTH-1:WIDTH]
                                                      : r_work[2*WIDTH-1:WIDTH];

  div_iterative_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_stepWork)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: annul only matters before the result exists, and DONE
  // waits for the controller to drop start so each result is seen once.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      DIV_IDLE: begin
        if (w_accept) begin
          w_nextState = w_divisorZero ? DIV_DZERO : DIV_BUSY;
        end
      end
      DIV_DZERO: begin
        w_nextState = bus.annul_i ? DIV_IDLE : DIV_DONE;
      end
      DIV_BUSY: begin
        if (bus.annul_i) begin
          w_nextState = DIV_IDLE;
        end else if (r_cnt == LAST_CNT) begin
          w_nextState = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (!bus.start_i) begin
          w_nextState = DIV_IDLE;
        end
      end
      default: w_nextState = DIV_IDLE;
    endcase
  end

  // Output decode: turns the current state into the datapath strobes that
  // the registered datapath below acts on.
  always_comb begin
    w_loadOperands  = 1'b0;
    w_doStep        = 1'b0;
    w_loadResult    = 1'b0;
    w_setZeroResult = 1'b0;
    w_clearOutputs  = 1'b0;
    case (r_state)
      DIV_IDLE: begin
        w_clearOutputs = 1'b1;
        w_loadOperands = w_accept && !w_divisorZero;
      end
      DIV_DZERO: begin
        w_setZeroResult = !bus.annul_i;
      end
      DIV_BUSY: begin
        if (!bus.annul_i) begin
          if (r_cnt == LAST_CNT) begin
            w_loadResult = 1'b1;
          end else begin
            w_doStep = 1'b1;
          end
        end
      end
      DIV_DONE: begin
        w_clearOutputs = !bus.start_i;
      end
      default: w_clearOutputs = 1'b1;
    endcase
  end

  // Operand capture and iteration: the magnitudes and sign bits are latched
  // at start so later operand changes cannot disturb the divide in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_work        <= '0;
      r_divisor     <= '0;
      r_dividendNeg <= 1'b0;
      r_divisorNeg  <= 1'b0;
      r_signedDiv   <= 1'b0;
      r_cnt         <= '0;
    end else if (w_loadOperands) begin
      r_work        <= {{(WIDTH+1){1'b0}}, w_absDividend};
      r_divisor     <= w_absDivisor;
      r_dividendNeg <= bus.opdata1_i[WIDTH-1];
      r_divisorNeg  <= bus.opdata2_i[WIDTH-1];
      r_signedDiv   <= bus.signed_div_i;
      r_cnt         <= '0;
    end else if (w_doStep) begin
      r_work <= w_stepWork;
      r_cnt  <= r_cnt + CNT_WIDTH'(1);
    end
  end

  // Registered result and ready towards the controller
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
      r_ready  <= 1'b0;
    end else if (w_loadResult) begin
      r_result <= {w_remainder, w_quotient};
      r_ready  <= 1'b1;
    end else if (w_setZeroResult) begin
      r_result <= '0;
      r_ready  <= 1'b1;
    end else if (w_clearOutputs) begin
      r_result <= '0;
      r_ready  <= 1'b0;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;

endmodule

// File: tb/tb_div_iterative.sv
// -----------------------------------------------------------------------------
// tb_div_iterative
// Purpose : Directed self-checking bench for div_iterative with hand-computed
//           expected quotients, remainders and latencies.
// -----------------------------------------------------------------------------
module tb_div_iterative;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;
  int   edges;
  logic readySeen;

  div_iterative_if bus ();

  div_iterative dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Lets the start edge (edge 0) happen, then scrambles the operands and
  // counts further edges until ready_o rises, with a bound
  task automatic waitReady(output int edgeCount);
    @(posedge clk);
    #1;
    bus.opdata1_i    = ~bus.opdata1_i;
    bus.opdata2_i    = bus.opdata2_i + 32'd5;
    bus.signed_div_i = ~bus.signed_div_i;
    edgeCount = 0;
    while (bus.ready_o !== 1'b1 && edgeCount < 200) begin
      @(posedge clk);
      #1;
      edgeCount++;
    end
  endtask

  // Full transaction: start, latency/result, hold with annul ignored, release
  task automatic applyStimulus(input string tag, input logic sgn,
                               input logic [31:0] dividend, input logic [31:0] divisor,
                               input int expLatency, input logic [63:0] expResult);
    int lat;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = dividend;
    bus.opdata2_i    = divisor;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    waitReady(lat);
    checkOutput({tag, "/latency"}, 64'(lat), 64'(expLatency));
    checkOutput({tag, "/result"}, bus.result_o, expResult);
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "/holdReady"}, 64'(bus.ready_o), 64'd1);
    checkOutput({tag, "/holdResult"}, bus.result_o, expResult);
    bus.annul_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "/clearReady"}, 64'(bus.ready_o), 64'd0);
    checkOutput({tag, "/clearResult"}, bus.result_o, 64'd0);
  endtask

  // Main directed sequence
  initial begin
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #12;
    checkOutput("reset/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("reset/result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    applyStimulus("u100div7",       1'b0, 32'd100,       32'd7,         33, 64'h00000002_0000000E);
    applyStimulus("sNeg7div2",      1'b1, 32'hFFFFFFF9,  32'd2,         33, 64'hFFFFFFFF_FFFFFFFD);
    applyStimulus("s7divNeg2",      1'b1, 32'd7,         32'hFFFFFFFE,  33, 64'h00000001_FFFFFFFD);
    applyStimulus("sNeg100divNeg7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  33, 64'hFFFFFFFE_0000000E);
    applyStimulus("sMinDivNeg1",    1'b1, 32'h80000000,  32'hFFFFFFFF,  33, 64'h00000000_80000000);
    applyStimulus("uMaxDiv1",       1'b0, 32'hFFFFFFFF,  32'd1,         33, 64'h00000000_FFFFFFFF);
    applyStimulus("uMinDivMax",     1'b0, 32'h80000000,  32'hFFFFFFFF,  33, 64'h80000000_00000000);
    applyStimulus("uMaxDiv65536",   1'b0, 32'hFFFFFFFF,  32'h00010000,  33, 64'h0000FFFF_0000FFFF);
    applyStimulus("u7div9",         1'b0, 32'd7,         32'd9,         33, 64'h00000007_00000000);
    applyStimulus("uDivZero",       1'b0, 32'd5,         32'd0,          1, 64'd0);
    applyStimulus("sDivZero",       1'b1, 32'hFFFFFFFB,  32'd0,          1, 64'd0);

    // Annul on BUSY edge 10, then an immediate new request with start held
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    readySeen = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready_o !== 1'b0) readySeen = 1'b1;
    end
    bus.annul_i = 1'b1;
    @(posedge clk);
    #1;
    if (bus.ready_o !== 1'b0) readySeen = 1'b1;
    checkOutput("annul/readyNeverRose", 64'(readySeen), 64'd0);
    bus.annul_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd9;
    bus.opdata2_i    = 32'd3;
    waitReady(edges);
    checkOutput("annul/restartLatency", 64'(edges), 64'd33);
    checkOutput("annul/restartResult", bus.result_o, 64'h00000000_00000003);
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("annul/clearReady", 64'(bus.ready_o), 64'd0);

    // Asynchronous reset in the middle of BUSY
    @(negedge clk);
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("busyReset/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("busyReset/result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("busyReset/idleReady", 64'(bus.ready_o), 64'd0);
    applyStimulus("afterBusyReset", 1'b0, 32'd1000, 32'd10, 33, 64'h00000000_00000064);

    // Asynchronous reset while holding a result in DONE
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    waitReady(edges);
    checkOutput("doneReset/preReady", 64'(bus.ready_o), 64'd1);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("doneReset/ready", 64'(bus.ready_o), 64'd0);
    checkOutput("doneReset/result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst         = 1'b1;
    applyStimulus("afterDoneReset", 1'b1, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
